// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared particle record layout, direction codes and FSM state type
//
// Purpose: constants and types shared by the motion-update datapath.
//   Particle record (97 bits): [96] valid, [31:0] x, [63:32] y, [95:64] z, two's complement.
//   Migration record (198 bits): [95:0] wrapped position, [191:96] velocity,
//   [197:192] direction, two bits per axis with x at the LSB.
// Ports: none (package).
package md_pkg;

    localparam int AXIS_W     = 32;
    localparam int REC_W      = 97;
    localparam int VALID_BIT  = 96;
    localparam int X_LO       = 0;
    localparam int Y_LO       = 32;
    localparam int Z_LO       = 64;
    localparam int POS_W      = 96;
    localparam int MIG_W      = 198;
    localparam int MIG_VEL_LO = 96;
    localparam int MIG_DIR_LO = 192;

    localparam logic [1:0] DIR_STAY = 2'b00;
    localparam logic [1:0] DIR_POS  = 2'b01;
    localparam logic [1:0] DIR_NEG  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LATCH,
        UPDATE,
        EMIT,
        FIN
    } state_t;

    function automatic logic [AXIS_W-1:0] axis_of(input logic [REC_W-1:0] rec, input int lo);
        return rec[lo +: AXIS_W];
    endfunction

endpackage

// File: rtl/axis_integrator.sv
// rtl/axis_integrator.sv - combinational single-axis position integrator with one-cell wrap
//
// Purpose: p' = p + (v >>> DT_SHIFT), folded back by one cell edge when it leaves [0, 2^CELL_SHIFT).
// Ports:
//   p        in  32  current coordinate (signed)
//   v        in  32  velocity (signed)
//   coord    out 32  coordinate after a single-step wrap
//   dir      out 2   DIR_STAY / DIR_POS / DIR_NEG
//   overflow out 1   wrapped coordinate is still outside the cell
module axis_integrator
    import md_pkg::*;
#(
    parameter int CELL_SHIFT = 24,
    parameter int DT_SHIFT   = 4
) (
    input  logic [AXIS_W-1:0] p,
    input  logic [AXIS_W-1:0] v,
    output logic [AXIS_W-1:0] coord,
    output logic [1:0]        dir,
    output logic              overflow
);

    localparam logic signed [AXIS_W:0] CELL = 33'(1) << CELL_SHIFT;

    logic signed [AXIS_W-1:0] d;
    logic signed [AXIS_W:0]   s;
    logic signed [AXIS_W:0]   w;

    always_comb begin
        d   = $signed(v) >>> DT_SHIFT;
        // Both operands sign-extended to 33 bits so the sum cannot wrap.
        s   = $signed({p[AXIS_W-1], p}) + $signed({d[AXIS_W-1], d});
        w   = s;
        dir = DIR_STAY;
        if (s < 0) begin
            w   = s + CELL;
            dir = DIR_NEG;
        end else if (s >= CELL) begin
            w   = s - CELL;
            dir = DIR_POS;
        end
        overflow = (w < 0) || (w >= CELL);
        coord    = w[AXIS_W-1:0];
    end

endmodule

// File: rtl/motion_update.sv
// rtl/motion_update.sv - per-cell position integration sweep with migration output
//
// Purpose: on start, walks every slot of the cell's position/velocity caches, integrates
// position, writes stayers back and hands leavers to the migration port, clearing their slots.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           begins a sweep when idle
//   addr     out 32 shared cache slot address (read and write)
//   p_rdata  in  97 position record, 1-cycle read latency
//   v_rdata  in  97 velocity record, 1-cycle read latency
//   p_wr_en  out 1  position write strobe, p_wdata out 97 write data
//   v_wr_en  out 1  velocity clear strobe
//   mig_valid/mig_ready/mig_data(198)  migration handshake
//   done     out 1  one-cycle end-of-sweep pulse
//   err      out 1  sticky: a displacement spanned more than one cell
module motion_update
    import md_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int CELL_SHIFT = 24,
    parameter int DT_SHIFT   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [31:0]        addr,
    input  logic [REC_W-1:0]   p_rdata,
    input  logic [REC_W-1:0]   v_rdata,
    output logic               p_wr_en,
    output logic [REC_W-1:0]   p_wdata,
    output logic               v_wr_en,
    output logic               mig_valid,
    input  logic               mig_ready,
    output logic [MIG_W-1:0]   mig_data,
    output logic               done,
    output logic               err
);

    state_t state, state_next;

    logic [AXIS_W-1:0] nx, ny, nz;
    logic [1:0]        dx, dy, dz;
    logic              ox, oy, oz;
    logic              rec_valid;
    logic              moving;
    logic              last;

    logic              wr_q;
    logic              mig_pend;
    logic [REC_W-1:0]  wdata_q;

    // Velocity valid bit is not needed: the position valid bit governs the slot.
    logic unused_vvalid;
    assign unused_vvalid = v_rdata[VALID_BIT];

    axis_integrator #(.CELL_SHIFT(CELL_SHIFT), .DT_SHIFT(DT_SHIFT)) u_ax (
        .p(axis_of(p_rdata, X_LO)), .v(axis_of(v_rdata, X_LO)),
        .coord(nx), .dir(dx), .overflow(ox)
    );
    axis_integrator #(.CELL_SHIFT(CELL_SHIFT), .DT_SHIFT(DT_SHIFT)) u_ay (
        .p(axis_of(p_rdata, Y_LO)), .v(axis_of(v_rdata, Y_LO)),
        .coord(ny), .dir(dy), .overflow(oy)
    );
    axis_integrator #(.CELL_SHIFT(CELL_SHIFT), .DT_SHIFT(DT_SHIFT)) u_az (
        .p(axis_of(p_rdata, Z_LO)), .v(axis_of(v_rdata, Z_LO)),
        .coord(nz), .dir(dz), .overflow(oz)
    );

    assign rec_valid = p_rdata[VALID_BIT];
    assign moving    = (dx != DIR_STAY) || (dy != DIR_STAY) || (dz != DIR_STAY);
    assign last      = (addr == 32'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        p_wr_en    = 1'b0;
        p_wdata    = '0;
        v_wr_en    = 1'b0;
        mig_valid  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:   if (start) state_next = ISSUE;
            ISSUE:  state_next = LATCH;
            LATCH:  state_next = UPDATE;
            UPDATE: begin
                // Strobes are masked by reset so an abort never leaves a partial write.
                if (wr_q && !reset) begin
                    p_wr_en = 1'b1;
                    p_wdata = wdata_q;
                end
                if (mig_pend)  state_next = EMIT;
                else if (last) state_next = FIN;
                else           state_next = ISSUE;
            end
            EMIT: begin
                mig_valid = 1'b1;
                if (mig_ready) begin
                    // Handshake cycle: invalidate the position slot (all-zero data) and clear velocity.
                    p_wr_en    = !reset;
                    v_wr_en    = !reset;
                    state_next = last ? FIN : ISSUE;
                end
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Integration runs on the raw read data during LATCH; the decision and the write or
    // migration payload are registered so UPDATE/EMIT present them from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr     <= '0;
            wr_q     <= 1'b0;
            mig_pend <= 1'b0;
            wdata_q  <= '0;
            mig_data <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) addr <= '0;
                LATCH: begin
                    wr_q     <= rec_valid && !moving;
                    mig_pend <= rec_valid && moving;
                    wdata_q  <= {1'b1, nz, ny, nx};
                    if (rec_valid && moving) begin
                        mig_data <= {dz, dy, dx, v_rdata[POS_W-1:0], nz, ny, nx};
                    end
                    if (rec_valid && (ox || oy || oz)) begin
                        err <= 1'b1;
                    end
                end
                UPDATE: if (!mig_pend && !last) addr <= addr + 32'd1;
                EMIT:   if (mig_ready && !last) addr <= addr + 32'd1;
                default: ;
            endcase
        end
    end

endmodule
